// File: rtl/sdspi_types.sv
// Shared types for the SD SPI burst engine: op codes, SPI mode, FSM states
// and default divisors.
package sdspi_types;

   localparam int DEF_DIV_BITS  = 10;
   localparam int DEF_SLOW_DIV  = 124;
   localparam int DEF_FAST_DIV  = 1;
   localparam int DEF_NUM_CS    = 2;
   localparam int DEF_MAX_BYTES = 4;

   // The first six encodings are those of the single-byte engine.
   typedef enum logic [2:0] {
      spiNOP  = 3'd0,
      spiCSL  = 3'd1,
      spiCSH  = 3'd2,
      spiTR   = 3'd3,
      spiFAST = 3'd4,
      spiSLOW = 3'd5,
      spiDIV  = 3'd6,
      spiMODE = 3'd7
   } spiOP_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam spi_mode_t RESET_MODE = '{cpol: 1'b1, cpha: 1'b1};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PH_A   = 3'd1,
      PH_B   = 3'd2,
      GUARD1 = 3'd3,
      GUARD2 = 3'd4
   } state_t;

   function automatic logic sclk_level(input state_t s, input spi_mode_t m);
      case (s)
         PH_A:    return m.cpol ^ m.cpha;
         PH_B:    return ~(m.cpol ^ m.cpha);
         default: return m.cpol;
      endcase
   endfunction

endpackage

// File: rtl/sdspi_halfclk.sv
// Half-period counter: counts clkdiv down to zero, ticks for one cycle on the
// terminal count and reloads, so each half-period lasts div+1 clocks.
module sdspi_halfclk #(
   parameter int DIV_BITS = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                en,
   input  logic [DIV_BITS-1:0] div,
   output logic                tick
);

   logic [DIV_BITS-1:0] cnt;

   assign tick = en && (cnt == '0);

   // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load || tick) begin
         cnt <= div;
      end else if (en) begin
         cnt <= cnt - DIV_BITS'(1);
      end
   end

endmodule

// File: rtl/sdspi_burst.sv
// Multi-byte SD SPI engine: op/DONE handshake, runtime divisor and SPI mode,
// bursts of 1..MAX_BYTES bytes, NUM_CS active-low chip selects.
module sdspi_burst
   import sdspi_types::*;
#(
   parameter int DIV_BITS  = DEF_DIV_BITS,
   parameter int SLOW_DIV  = DEF_SLOW_DIV,
   parameter int FAST_DIV  = DEF_FAST_DIV,
   parameter int NUM_CS    = DEF_NUM_CS,
   parameter int MAX_BYTES = DEF_MAX_BYTES,
   localparam int SEL_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
   localparam int LEN_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
   localparam int W        = 8 * MAX_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   input  spiOP_t            spiOP,
   input  logic [SEL_W-1:0]  spiSEL,
   input  logic [LEN_W-1:0]  spiLEN,
   input  logic [W-1:0]      spiTXD,
   output logic [W-1:0]      spiRXD,
   input  logic              spiMISO,
   output logic              spiMOSI,
   output logic              spiSCLK,
   output logic [NUM_CS-1:0] spiCS,
   output logic              spiBUSY,
   output logic              spiDONE
);

   localparam int BIT_W = $clog2(W);

   state_t              state, state_d;
   logic [DIV_BITS-1:0] clkdiv, clkdiv_d;
   spi_mode_t           mode, mode_d;
   logic [NUM_CS-1:0]   cs, cs_d;
   logic [W-1:0]        txsr, txsr_d;
   logic [W-1:0]        rxsr, rxsr_d;
   logic [W-1:0]        rxd, rxd_d;
   logic [BIT_W-1:0]    bitcnt, bitcnt_d;
   logic                done_d;
   logic                sclk;
   logic                done;
   logic                accept;
   logic                tick;
   int                  n_bytes;

   assign accept = (state == IDLE) && (spiOP == spiTR);

   sdspi_halfclk #(
      .DIV_BITS (DIV_BITS)
   ) u_halfclk (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .en   (state != IDLE),
      .div  (clkdiv),
      .tick (tick)
   );

   always_comb begin
      n_bytes = int'(spiLEN) + 1;
      if (n_bytes > MAX_BYTES) n_bytes = MAX_BYTES;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state;
      clkdiv_d = clkdiv;
      mode_d   = mode;
      cs_d     = cs;
      txsr_d   = txsr;
      rxsr_d   = rxsr;
      rxd_d    = rxd;
      bitcnt_d = bitcnt;
      done_d   = 1'b0;
      case (state)
         IDLE: begin
            case (spiOP)
               spiCSL: begin
                  for (int i = 0; i < NUM_CS; i++) cs_d[i] = (int'(spiSEL) != i);
               end
               spiCSH:  cs_d     = '1;
               spiFAST: clkdiv_d = DIV_BITS'(FAST_DIV);
               spiSLOW: clkdiv_d = DIV_BITS'(SLOW_DIV);
               spiDIV:  clkdiv_d = spiTXD[DIV_BITS-1:0];
               spiMODE: mode_d   = spi_mode_t'(spiTXD[1:0]);
               spiTR: begin
                  // Left-justify the burst so bit 8N-1 leaves first; vacated bits fill with 1.
                  txsr_d   = ~((~spiTXD) << (8 * (MAX_BYTES - n_bytes)));
                  rxsr_d   = '0;
                  bitcnt_d = BIT_W'(8 * n_bytes - 1);
                  state_d  = PH_A;
               end
               default: ;
            endcase
         end
         PH_A: begin
            if (tick) begin
               rxsr_d  = {rxsr[W-2:0], spiMISO};
               state_d = PH_B;
            end
         end
         PH_B: begin
            if (tick) begin
               if (bitcnt != '0) begin
                  txsr_d   = {txsr[W-2:0], 1'b1};
                  bitcnt_d = bitcnt - BIT_W'(1);
                  state_d  = PH_A;
               end else begin
                  state_d = GUARD1;
               end
            end
         end
         GUARD1: begin
            if (tick) state_d = GUARD2;
         end
         GUARD2: begin
            if (tick) begin
               rxd_d   = rxsr;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         clkdiv <= DIV_BITS'(SLOW_DIV);
         mode   <= RESET_MODE;
         cs     <= '1;
         txsr   <= '1;
         rxsr   <= '1;
         rxd    <= '0;
         bitcnt <= '0;
         done   <= 1'b0;
         sclk   <= 1'b1;
      end else begin
         state  <= state_d;
         clkdiv <= clkdiv_d;
         mode   <= mode_d;
         cs     <= cs_d;
         txsr   <= txsr_d;
         rxsr   <= rxsr_d;
         rxd    <= rxd_d;
         bitcnt <= bitcnt_d;
         done   <= done_d;
         // Level of the state being entered, so SCLK edges line up with txsr shifts.
         sclk   <= sclk_level(state_d, mode_d);
      end
   end

   assign spiRXD  = rxd;
   assign spiMOSI = txsr[W-1];
   assign spiSCLK = sclk;
   assign spiCS   = cs;
   assign spiBUSY = (state != IDLE);
   assign spiDONE = done;

endmodule

// File: tb/tb_sdspi_burst.sv
// Self-checking bench for sdspi_burst: IDLE-op table, transfer table,
// hand-written busy/reset sequences and randomized loopback bursts.
module tb_sdspi_burst;
   import sdspi_types::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   spiOP_t      spiOP;
   logic [0:0]  spiSEL;
   logic [1:0]  spiLEN;
   logic [31:0] spiTXD;
   logic [31:0] spiRXD;
   logic        spiMISO;
   logic        spiMOSI;
   logic        spiSCLK;
   logic [1:0]  spiCS;
   logic        spiBUSY;
   logic        spiDONE;

   logic        loop_en  = 1'b1;
   logic        miso_drv = 1'b1;

   assign spiMISO = loop_en ? spiMOSI : miso_drv;

   always #5 clk = ~clk;

   sdspi_burst dut (
      .clk     (clk),
      .rst     (rst),
      .spiOP   (spiOP),
      .spiSEL  (spiSEL),
      .spiLEN  (spiLEN),
      .spiTXD  (spiTXD),
      .spiRXD  (spiRXD),
      .spiMISO (spiMISO),
      .spiMOSI (spiMOSI),
      .spiSCLK (spiSCLK),
      .spiCS   (spiCS),
      .spiBUSY (spiBUSY),
      .spiDONE (spiDONE)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [1:0] tb_mode  = 2'd3;
   logic [1:0] tb_cs    = 2'b11;
   logic       prev_sclk = 1'b1;
   logic       mosi_q[$];

   // Slave-side view: capture MOSI on each sampling edge of SCLK for the current mode.
   always @(negedge clk) begin
      if (spiBUSY && (spiSCLK !== prev_sclk) && (spiSCLK == (tb_mode[1] == tb_mode[0])))
         mosi_q.push_back(spiMOSI);
      prev_sclk = spiSCLK;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic issue(input spiOP_t op, input logic sel, input logic [31:0] txd);
      @(posedge clk); #1;
      spiOP = op; spiSEL = sel; spiTXD = txd;
      @(posedge clk); #1;
      spiOP = spiNOP;
      case (op)
         spiMODE: tb_mode = txd[1:0];
         spiCSL:  tb_cs   = sel ? 2'b01 : 2'b10;
         spiCSH:  tb_cs   = 2'b11;
         default: ;
      endcase
   endtask

   task automatic do_xfer(input logic [1:0] len, input logic [31:0] txd,
                          input logic [31:0] exp_rxd, input int exp_lat, input string name);
      int          n;
      int          nb;
      logic [63:0] mask;
      logic [63:0] bits;
      nb   = int'(len) + 1;
      mask = (64'd1 << (8 * nb)) - 64'd1;
      mosi_q.delete();
      @(posedge clk); #1;
      spiOP = spiTR; spiLEN = len; spiTXD = txd;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            spiOP = spiNOP;
            check({name, "_busy"}, 64'(spiBUSY), 64'd1);
         end
      end while (!spiDONE && n < 5000);
      check({name, "_latency"}, 64'(n), 64'(exp_lat));
      check({name, "_busy_at_done"}, 64'(spiBUSY), 64'd0);
      check({name, "_rxd"}, 64'(spiRXD), 64'(exp_rxd));
      @(posedge clk); #1;
      check({name, "_done_width"}, 64'(spiDONE), 64'd0);
      check({name, "_pulses"}, 64'(mosi_q.size()), 64'(8 * nb));
      bits = '0;
      foreach (mosi_q[i]) bits = {bits[62:0], mosi_q[i]};
      check({name, "_mosi_bits"}, bits, 64'(txd) & mask);
      check({name, "_sclk_idle"}, 64'(spiSCLK), 64'(tb_mode[1]));
      check({name, "_cs"}, 64'(spiCS), 64'(tb_cs));
   endtask

   typedef struct {
      spiOP_t      op;
      logic        sel;
      logic [31:0] txd;
      logic [1:0]  exp_cs;
      logic        exp_sclk;
      string       name;
   } op_vec_t;

   typedef struct {
      spiOP_t      div_op;
      logic [31:0] div_val;
      logic        set_mode;
      logic [1:0]  mode;
      logic [1:0]  len;
      logic [31:0] txd;
      logic [31:0] exp_rxd;
      int          exp_lat;
      logic        loop;
      logic        miso;
      string       name;
   } xfer_vec_t;

   op_vec_t   ov[10];
   xfer_vec_t xv[10];

   initial begin
      int          n;
      int          dones;
      logic [1:0]  r_mode;
      logic [31:0] r_div;
      logic [1:0]  r_len;
      logic [31:0] r_txd;
      int          r_nb;
      logic [63:0] r_mask;

      ov[0] = '{spiCSL,  1'b1, 32'd0, 2'b01, 1'b1, "csl_sel1"};
      ov[1] = '{spiCSH,  1'b0, 32'd0, 2'b11, 1'b1, "csh"};
      ov[2] = '{spiCSL,  1'b0, 32'd0, 2'b10, 1'b1, "csl_sel0"};
      ov[3] = '{spiNOP,  1'b1, 32'd0, 2'b10, 1'b1, "nop"};
      ov[4] = '{spiMODE, 1'b0, 32'd0, 2'b10, 1'b0, "mode0_idle"};
      ov[5] = '{spiMODE, 1'b0, 32'd2, 2'b10, 1'b1, "mode2_idle"};
      ov[6] = '{spiMODE, 1'b0, 32'd1, 2'b10, 1'b0, "mode1_idle"};
      ov[7] = '{spiSLOW, 1'b0, 32'd0, 2'b10, 1'b0, "slow_idle"};
      ov[8] = '{spiMODE, 1'b0, 32'd3, 2'b10, 1'b1, "mode3_idle"};
      ov[9] = '{spiCSH,  1'b0, 32'd0, 2'b11, 1'b1, "csh_again"};

      xv[0] = '{spiNOP,  32'd0, 1'b0, 2'd3, 2'd0, 32'h000000A5, 32'h000000A5, 2251, 1'b1, 1'b1, "reset_div_a5"};
      xv[1] = '{spiFAST, 32'd0, 1'b0, 2'd3, 2'd3, 32'hDEADBEEF, 32'hDEADBEEF, 133,  1'b1, 1'b1, "fast_4byte"};
      xv[2] = '{spiNOP,  32'd0, 1'b1, 2'd0, 2'd0, 32'hFFFFFF3C, 32'h0000003C, 37,   1'b1, 1'b1, "mode0_3c"};
      xv[3] = '{spiNOP,  32'd0, 1'b1, 2'd1, 2'd0, 32'hFFFFFF3C, 32'h0000003C, 37,   1'b1, 1'b1, "mode1_3c"};
      xv[4] = '{spiNOP,  32'd0, 1'b1, 2'd2, 2'd0, 32'hFFFFFF3C, 32'h0000003C, 37,   1'b1, 1'b1, "mode2_3c"};
      xv[5] = '{spiNOP,  32'd0, 1'b1, 2'd3, 2'd0, 32'hFFFFFF3C, 32'h0000003C, 37,   1'b1, 1'b1, "mode3_3c"};
      xv[6] = '{spiDIV,  32'd0, 1'b0, 2'd3, 2'd0, 32'h0000005A, 32'h0000005A, 19,   1'b1, 1'b1, "div0"};
      xv[7] = '{spiDIV,  32'd2, 1'b0, 2'd3, 2'd1, 32'h00001234, 32'h00001234, 103,  1'b1, 1'b1, "div2_2byte"};
      xv[8] = '{spiSLOW, 32'd0, 1'b0, 2'd3, 2'd0, 32'h000000C3, 32'h000000C3, 2251, 1'b1, 1'b1, "slow_c3"};
      xv[9] = '{spiFAST, 32'd0, 1'b0, 2'd3, 2'd1, 32'h00000000, 32'h0000FFFF, 69,   1'b0, 1'b1, "miso_high"};

      spiOP = spiNOP; spiSEL = '0; spiLEN = '0; spiTXD = '0;

      // Reset state
      #12;
      check("rst_cs",   64'(spiCS),   64'h3);
      check("rst_sclk", 64'(spiSCLK), 64'd1);
      check("rst_mosi", 64'(spiMOSI), 64'd1);
      check("rst_rxd",  64'(spiRXD),  64'd0);
      check("rst_busy", 64'(spiBUSY), 64'd0);
      check("rst_done", 64'(spiDONE), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      foreach (ov[i]) begin
         issue(ov[i].op, ov[i].sel, ov[i].txd);
         check({ov[i].name, "_cs"},   64'(spiCS),   64'(ov[i].exp_cs));
         check({ov[i].name, "_sclk"}, 64'(spiSCLK), 64'(ov[i].exp_sclk));
      end

      foreach (xv[i]) begin
         if (xv[i].div_op != spiNOP) issue(xv[i].div_op, 1'b0, xv[i].div_val);
         if (xv[i].set_mode) issue(spiMODE, 1'b0, {30'd0, xv[i].mode});
         loop_en  = xv[i].loop;
         miso_drv = xv[i].miso;
         do_xfer(xv[i].len, xv[i].txd, xv[i].exp_rxd, xv[i].exp_lat, xv[i].name);
         loop_en  = 1'b1;
      end

      // Ops presented while busy are dropped: CS stays, no second transfer
      issue(spiFAST, 1'b0, 32'd0);
      @(posedge clk); #1;
      spiOP = spiTR; spiLEN = 2'd0; spiTXD = 32'h81;
      @(posedge clk); #1;
      spiOP = spiCSL; spiSEL = 1'b0;
      @(posedge clk); #1;
      spiOP = spiTR; spiTXD = 32'h7E;
      @(posedge clk); #1;
      spiOP = spiNOP;
      check("busy_cs_held", 64'(spiCS), 64'(tb_cs));
      n = 3;
      while (!spiDONE && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_latency", 64'(n), 64'd37);
      check("busy_rxd", 64'(spiRXD), 64'h81);
      dones = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (spiDONE) dones++;
      end
      check("busy_no_second_done", 64'(dones), 64'd0);
      check("busy_cs_after", 64'(spiCS), 64'(tb_cs));

      // Asynchronous reset in the middle of a burst
      issue(spiCSL, 1'b0, 32'd0);
      issue(spiMODE, 1'b0, 32'd0);
      issue(spiDIV, 1'b0, 32'd7);
      @(posedge clk); #1;
      spiOP = spiTR; spiLEN = 2'd3; spiTXD = 32'h0F0F0F0F;
      @(posedge clk); #1;
      spiOP = spiNOP;
      repeat (100) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      tb_mode = 2'd3;
      tb_cs   = 2'b11;
      check("mid_rst_cs",   64'(spiCS),   64'h3);
      check("mid_rst_sclk", 64'(spiSCLK), 64'd1);
      check("mid_rst_mosi", 64'(spiMOSI), 64'd1);
      check("mid_rst_rxd",  64'(spiRXD),  64'd0);
      check("mid_rst_busy", 64'(spiBUSY), 64'd0);
      check("mid_rst_done", 64'(spiDONE), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      dones = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (spiDONE) dones++;
      end
      check("mid_rst_no_done", 64'(dones), 64'd0);
      do_xfer(2'd0, 32'h00000096, 32'h00000096, 2251, "after_reset");

      // Randomized loopback bursts against the arithmetic model
      for (int k = 0; k < 8; k++) begin
         r_mode = 2'($urandom_range(0, 3));
         r_div  = 32'($urandom_range(0, 3));
         r_len  = 2'($urandom_range(0, 3));
         r_txd  = $urandom;
         r_nb   = int'(r_len) + 1;
         r_mask = (64'd1 << (8 * r_nb)) - 64'd1;
         issue(spiMODE, 1'b0, {30'd0, r_mode});
         issue(spiDIV, 1'b0, r_div);
         do_xfer(r_len, r_txd, 32'(64'(r_txd) & r_mask),
                 1 + (16 * r_nb + 2) * (int'(r_div) + 1), $sformatf("rand%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
